// File: rtl/du_mem_unit.sv
// du_mem_unit: data-unit execution stage. Takes one load/store at a time from
// the issue window, computes its effective address and runs a req/ack
// handshake with data memory. It then returns the writeback/wakeup tuple
// and drives DU_busy back to the window.
module du_mem_unit #(
  parameter int IW_DEPTH = 16,
  parameter int ADDR_W   = 32,
  localparam int WW      = $clog2(IW_DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              SL_DU_en,
  input  logic [WW-1:0]     SL_DU_Commit_Window,
  input  logic [5:0]        SL_DU_operation,
  input  logic [31:0]       SL_DU_imm,
  input  logic [5:0]        SL_DU_Rdst,
  input  logic [31:0]       rs1_data,
  input  logic [31:0]       rs2_data,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [3:0]        mem_be,
  output logic [31:0]       mem_wdata,
  input  logic              mem_ack,
  input  logic [31:0]       mem_rdata,
  output logic              DU_Commit,
  output logic [5:0]        DU_Phydst,
  output logic [WW-1:0]     WB_DU_Commit_Window,
  output logic [31:0]       DU_wdata,
  output logic              DU_fault,
  output logic              DU_busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    WB    = 2'd2,
    DRAIN = 2'd3
  } state_t;

  localparam logic [2:0] OP_LW  = 3'd0;
  localparam logic [2:0] OP_LH  = 3'd1;
  localparam logic [2:0] OP_LHU = 3'd2;
  localparam logic [2:0] OP_LB  = 3'd3;
  localparam logic [2:0] OP_LBU = 3'd4;
  localparam logic [2:0] OP_SW  = 3'd5;
  localparam logic [2:0] OP_SH  = 3'd6;
  localparam logic [2:0] OP_SB  = 3'd7;

  state_t        state_q, state_d;

  // Instruction fields latched at issue and held for the whole transaction.
  logic [2:0]    op_q;
  logic [31:0]   ea_q;
  logic [31:0]   sdata_q;
  logic [5:0]    rdst_q;
  logic [WW-1:0] win_q;

  // Registered writeback tuple.
  logic          commit_q;
  logic          fault_q;
  logic [5:0]    phydst_q;
  logic [WW-1:0] window_q;
  logic [31:0]   wdata_q;

  // Issue-cycle decode.
  logic [31:0]   issue_ea;
  logic [2:0]    issue_op;
  logic          issue_illegal;
  logic          issue_misaligned;
  logic          issue_fault;
  logic          issue_take;

  // Load formatting.
  logic [31:0]   load_shifted;
  logic [31:0]   load_result;
  logic          op_is_store;
  logic          enter_wb;

  logic [31:0]   ea_word;

  assign issue_ea      = rs1_data + SL_DU_imm;
  assign issue_op      = SL_DU_operation[2:0];
  assign issue_illegal = |SL_DU_operation[5:3];
  assign issue_fault   = issue_illegal | issue_misaligned;
  assign issue_take    = (state_q == IDLE) & SL_DU_en & ~flush;

  // Alignment check on the freshly computed effective address.
  always_comb begin
    issue_misaligned = 1'b0;
    case (issue_op)
      OP_LW, OP_SW:         issue_misaligned = |issue_ea[1:0];
      OP_LH, OP_LHU, OP_SH: issue_misaligned = issue_ea[0];
      default:              issue_misaligned = 1'b0;
    endcase
  end

  assign op_is_store  = (op_q == OP_SW) | (op_q == OP_SH) | (op_q == OP_SB);
  assign load_shifted = mem_rdata >> {ea_q[1:0], 3'b000};

  // Select the addressed lane and sign- or zero-extend it (little-endian).
  always_comb begin
    load_result = mem_rdata;
    case (op_q)
      OP_LH:   load_result = {{16{load_shifted[15]}}, load_shifted[15:0]};
      OP_LHU:  load_result = {16'h0000, load_shifted[15:0]};
      OP_LB:   load_result = {{24{load_shifted[7]}}, load_shifted[7:0]};
      OP_LBU:  load_result = {24'h000000, load_shifted[7:0]};
      default: load_result = mem_rdata;
    endcase
  end

  // Next-state logic; once a request is raised it is only ended by mem_ack or rst.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (issue_take) begin
          state_d = issue_fault ? WB : REQ;
        end
      end
      REQ: begin
        if (mem_ack) begin
          state_d = flush ? IDLE : WB;
        end else if (flush) begin
          state_d = DRAIN;
        end
      end
      WB: begin
        state_d = IDLE;
      end
      DRAIN: begin
        if (mem_ack) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign enter_wb = (state_d == WB);

  // State register, issue latches and the registered writeback tuple.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      op_q     <= 3'd0;
      ea_q     <= 32'h0;
      sdata_q  <= 32'h0;
      rdst_q   <= 6'd0;
      win_q    <= '0;
      commit_q <= 1'b0;
      fault_q  <= 1'b0;
      phydst_q <= 6'd0;
      window_q <= '0;
      wdata_q  <= 32'h0;
    end else begin
      state_q <= state_d;
      if (issue_take) begin
        op_q    <= issue_op;
        ea_q    <= issue_ea;
        sdata_q <= rs2_data;
        rdst_q  <= SL_DU_Rdst;
        win_q   <= SL_DU_Commit_Window;
      end
      commit_q <= enter_wb;
      fault_q  <= enter_wb & (state_q == IDLE);
      if (enter_wb) begin
        phydst_q <= (state_q == IDLE) ? SL_DU_Rdst : rdst_q;
        window_q <= (state_q == IDLE) ? SL_DU_Commit_Window : win_q;
        wdata_q  <= ((state_q == REQ) & ~op_is_store) ? load_result : 32'h0;
      end else begin
        phydst_q <= 6'd0;
        window_q <= '0;
        wdata_q  <= 32'h0;
      end
    end
  end

  assign mem_req = (state_q == REQ) | (state_q == DRAIN);
  assign ea_word = {ea_q[31:2], 2'b00};

  // Memory-side drive, straight from latched state so it is stable while requesting.
  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_be    = 4'b0000;
    mem_wdata = 32'h0;
    if (mem_req) begin
      mem_we   = op_is_store;
      mem_addr = ea_word[ADDR_W-1:0];
      mem_be   = 4'b1111;
      case (op_q)
        OP_SW: begin
          mem_wdata = sdata_q;
        end
        OP_SH: begin
          mem_be    = 4'b0011 << ea_q[1:0];
          mem_wdata = {2{sdata_q[15:0]}};
        end
        OP_SB: begin
          mem_be    = 4'b0001 << ea_q[1:0];
          mem_wdata = {4{sdata_q[7:0]}};
        end
        default: begin
          mem_be    = 4'b1111;
          mem_wdata = 32'h0;
        end
      endcase
    end
  end

  // A flush in the writeback cycle kills the commit pulse that is already on its way out.
  assign DU_Commit           = commit_q & ~flush;
  assign DU_fault            = fault_q & ~flush;
  assign DU_Phydst           = phydst_q;
  assign WB_DU_Commit_Window = window_q;
  assign DU_wdata            = wdata_q;
  assign DU_busy             = (state_q != IDLE);

endmodule

// File: tb/tb_du_mem_unit.sv
// tb_du_mem_unit: directed, table-driven bench for du_mem_unit, plus
// hand-written sequences for flush, busy-issue and reset corner cases.
module tb_du_mem_unit;

  localparam int WW = 4;

  typedef struct {
    string       name;
    logic [5:0]  op;
    logic [31:0] rs1;
    logic [31:0] imm;
    logic [31:0] rs2;
    logic [5:0]  rdst;
    logic [3:0]  win;
    int          ack_delay;
    logic [31:0] rdata;
    logic        exp_fault;
    logic [31:0] exp_addr;
    logic        exp_we;
    logic [3:0]  exp_be;
    logic [31:0] exp_mem_wdata;
    logic [31:0] exp_result;
  } vec_t;

  logic          clk;
  logic          rst;
  logic          flush;
  logic          SL_DU_en;
  logic [WW-1:0] SL_DU_Commit_Window;
  logic [5:0]    SL_DU_operation;
  logic [31:0]   SL_DU_imm;
  logic [5:0]    SL_DU_Rdst;
  logic [31:0]   rs1_data;
  logic [31:0]   rs2_data;
  logic          mem_req;
  logic          mem_we;
  logic [31:0]   mem_addr;
  logic [3:0]    mem_be;
  logic [31:0]   mem_wdata;
  logic          mem_ack;
  logic [31:0]   mem_rdata;
  logic          DU_Commit;
  logic [5:0]    DU_Phydst;
  logic [WW-1:0] WB_DU_Commit_Window;
  logic [31:0]   DU_wdata;
  logic          DU_fault;
  logic          DU_busy;

  int assert_count = 0;
  int fail_count   = 0;

  vec_t vecs[13];

  du_mem_unit #(.IW_DEPTH(16), .ADDR_W(32)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .flush               (flush),
    .SL_DU_en            (SL_DU_en),
    .SL_DU_Commit_Window (SL_DU_Commit_Window),
    .SL_DU_operation     (SL_DU_operation),
    .SL_DU_imm           (SL_DU_imm),
    .SL_DU_Rdst          (SL_DU_Rdst),
    .rs1_data            (rs1_data),
    .rs2_data            (rs2_data),
    .mem_req             (mem_req),
    .mem_we              (mem_we),
    .mem_addr            (mem_addr),
    .mem_be              (mem_be),
    .mem_wdata           (mem_wdata),
    .mem_ack             (mem_ack),
    .mem_rdata           (mem_rdata),
    .DU_Commit           (DU_Commit),
    .DU_Phydst           (DU_Phydst),
    .WB_DU_Commit_Window (WB_DU_Commit_Window),
    .DU_wdata            (DU_wdata),
    .DU_fault            (DU_fault),
    .DU_busy             (DU_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    assert_count++;
    if (actual !== expected) begin
      fail_count++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  // Drive one issue onto the SL_DU bus for the current cycle.
  task automatic applyStimulus(input logic [5:0] op, input logic [31:0] rs1, input logic [31:0] imm,
                               input logic [31:0] rs2, input logic [5:0] rdst, input logic [3:0] win);
    SL_DU_en            = 1'b1;
    SL_DU_operation     = op;
    rs1_data            = rs1;
    SL_DU_imm           = imm;
    rs2_data            = rs2;
    SL_DU_Rdst          = rdst;
    SL_DU_Commit_Window = win;
  endtask

  task automatic clearIssue();
    SL_DU_en            = 1'b0;
    SL_DU_operation     = 6'd0;
    rs1_data            = 32'h0;
    SL_DU_imm           = 32'h0;
    rs2_data            = 32'h0;
    SL_DU_Rdst          = 6'd0;
    SL_DU_Commit_Window = '0;
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_mem_req"}, {31'h0, mem_req}, 32'h0);
    checkOutput({tag, "_mem_we"}, {31'h0, mem_we}, 32'h0);
    checkOutput({tag, "_mem_addr"}, mem_addr, 32'h0);
    checkOutput({tag, "_mem_be"}, {28'h0, mem_be}, 32'h0);
    checkOutput({tag, "_mem_wdata"}, mem_wdata, 32'h0);
    checkOutput({tag, "_commit"}, {31'h0, DU_Commit}, 32'h0);
    checkOutput({tag, "_phydst"}, {26'h0, DU_Phydst}, 32'h0);
    checkOutput({tag, "_window"}, {28'h0, WB_DU_Commit_Window}, 32'h0);
    checkOutput({tag, "_du_wdata"}, DU_wdata, 32'h0);
    checkOutput({tag, "_fault"}, {31'h0, DU_fault}, 32'h0);
    checkOutput({tag, "_busy"}, {31'h0, DU_busy}, 32'h0);
  endtask

  // Issue at the current negedge, serve the memory, check writeback, and
  // return positioned at the first idle negedge (ready for the next issue).
  task automatic runVector(input vec_t v);
    applyStimulus(v.op, v.rs1, v.imm, v.rs2, v.rdst, v.win);
    @(negedge clk);
    clearIssue();
    if (v.exp_fault) begin
      checkOutput({v.name, "_commit"}, {31'h0, DU_Commit}, 32'h1);
      checkOutput({v.name, "_fault"}, {31'h0, DU_fault}, 32'h1);
      checkOutput({v.name, "_no_req"}, {31'h0, mem_req}, 32'h0);
      checkOutput({v.name, "_phydst"}, {26'h0, DU_Phydst}, {26'h0, v.rdst});
      checkOutput({v.name, "_window"}, {28'h0, WB_DU_Commit_Window}, {28'h0, v.win});
      checkOutput({v.name, "_wdata"}, DU_wdata, 32'h0);
    end else begin
      for (int k = 0; k < v.ack_delay; k++) begin
        checkOutput($sformatf("%s_req%0d", v.name, k), {31'h0, mem_req}, 32'h1);
        checkOutput($sformatf("%s_addr%0d", v.name, k), mem_addr, v.exp_addr);
        checkOutput($sformatf("%s_we%0d", v.name, k), {31'h0, mem_we}, {31'h0, v.exp_we});
        checkOutput($sformatf("%s_be%0d", v.name, k), {28'h0, mem_be}, {28'h0, v.exp_be});
        if (v.exp_we) begin
          checkOutput($sformatf("%s_mwdata%0d", v.name, k), mem_wdata, v.exp_mem_wdata);
        end
        checkOutput($sformatf("%s_nocommit%0d", v.name, k), {31'h0, DU_Commit}, 32'h0);
        checkOutput($sformatf("%s_busy%0d", v.name, k), {31'h0, DU_busy}, 32'h1);
        if (k == v.ack_delay - 1) begin
          mem_ack   = 1'b1;
          mem_rdata = v.rdata;
        end
        @(negedge clk);
        mem_ack   = 1'b0;
        mem_rdata = 32'h0;
      end
      checkOutput({v.name, "_commit"}, {31'h0, DU_Commit}, 32'h1);
      checkOutput({v.name, "_fault"}, {31'h0, DU_fault}, 32'h0);
      checkOutput({v.name, "_wb_no_req"}, {31'h0, mem_req}, 32'h0);
      checkOutput({v.name, "_phydst"}, {26'h0, DU_Phydst}, {26'h0, v.rdst});
      checkOutput({v.name, "_window"}, {28'h0, WB_DU_Commit_Window}, {28'h0, v.win});
      checkOutput({v.name, "_wdata"}, DU_wdata, v.exp_result);
    end
    checkOutput({v.name, "_wb_busy"}, {31'h0, DU_busy}, 32'h1);
    @(negedge clk);
    checkOutput({v.name, "_pulse_end"}, {31'h0, DU_Commit}, 32'h0);
    checkOutput({v.name, "_idle_busy"}, {31'h0, DU_busy}, 32'h0);
  endtask

  initial begin
    //             name        op       rs1           imm           rs2           rdst   win    dly rdata         flt   addr          we    be       mwdata        result
    vecs[0]  = '{"lw_basic",  6'd0, 32'h0000_0100, 32'h0000_0004, 32'h0,        6'd9,  4'd5,  3, 32'hDEAD_BEEF, 1'b0, 32'h0000_0104, 1'b0, 4'b1111, 32'h0,        32'hDEAD_BEEF};
    vecs[1]  = '{"lb_neg",    6'd3, 32'h0000_0200, 32'h0000_0003, 32'h0,        6'd10, 4'd1,  1, 32'h80FF_FF7F, 1'b0, 32'h0000_0200, 1'b0, 4'b1111, 32'h0,        32'hFFFF_FF80};
    vecs[2]  = '{"lbu",       6'd4, 32'h0000_0200, 32'h0000_0003, 32'h0,        6'd11, 4'd2,  2, 32'h80FF_FF7F, 1'b0, 32'h0000_0200, 1'b0, 4'b1111, 32'h0,        32'h0000_0080};
    vecs[3]  = '{"sh_hi",     6'd6, 32'h0000_0300, 32'h0000_0002, 32'h1234_ABCD, 6'd12, 4'd3,  2, 32'hFFFF_FFFF, 1'b0, 32'h0000_0300, 1'b1, 4'b1100, 32'hABCD_ABCD, 32'h0};
    vecs[4]  = '{"lw_misal",  6'd0, 32'h0000_0100, 32'h0000_0001, 32'h0,        6'd13, 4'd4,  0, 32'h0,         1'b1, 32'h0,         1'b0, 4'b0000, 32'h0,        32'h0};
    vecs[5]  = '{"illegal",   6'h08, 32'h0000_0100, 32'h0000_0000, 32'h0,       6'd14, 4'd6,  0, 32'h0,         1'b1, 32'h0,         1'b0, 4'b0000, 32'h0,        32'h0};
    vecs[6]  = '{"lh_neg",    6'd1, 32'h0000_0400, 32'h0000_0002, 32'h0,        6'd15, 4'd7,  1, 32'h8001_1234, 1'b0, 32'h0000_0400, 1'b0, 4'b1111, 32'h0,        32'hFFFF_8001};
    vecs[7]  = '{"lhu_hi",    6'd2, 32'h0000_0400, 32'h0000_0002, 32'h0,        6'd16, 4'd8,  1, 32'h8001_1234, 1'b0, 32'h0000_0400, 1'b0, 4'b1111, 32'h0,        32'h0000_8001};
    vecs[8]  = '{"sb_lane1",  6'd7, 32'h0000_04FF, 32'h0000_0002, 32'h0000_00A5, 6'd17, 4'd9,  1, 32'hFFFF_FFFF, 1'b0, 32'h0000_0500, 1'b1, 4'b0010, 32'hA5A5_A5A5, 32'h0};
    vecs[9]  = '{"sw_wrap",   6'd5, 32'h0000_0700, 32'hFFFF_FF00, 32'hCAFE_F00D, 6'd18, 4'd10, 2, 32'hFFFF_FFFF, 1'b0, 32'h0000_0600, 1'b1, 4'b1111, 32'hCAFE_F00D, 32'h0};
    vecs[10] = '{"sh_misal",  6'd6, 32'h0000_0300, 32'h0000_0003, 32'h1234_5678, 6'd19, 4'd11, 0, 32'h0,         1'b1, 32'h0,         1'b0, 4'b0000, 32'h0,        32'h0};
    vecs[11] = '{"lb_lane1",  6'd3, 32'h0000_0200, 32'h0000_0001, 32'h0,        6'd20, 4'd12, 1, 32'h80FF_FF7F, 1'b0, 32'h0000_0200, 1'b0, 4'b1111, 32'h0,        32'hFFFF_FFFF};
    vecs[12] = '{"lhu_lo",    6'd2, 32'h0000_0010, 32'h0000_0000, 32'h0,        6'd63, 4'd15, 1, 32'h8001_1234, 1'b0, 32'h0000_0010, 1'b0, 4'b1111, 32'h0,        32'h0000_1234};

    rst       = 1'b1;
    flush     = 1'b0;
    mem_ack   = 1'b0;
    mem_rdata = 32'h0;
    clearIssue();
    repeat (3) @(negedge clk);
    checkAllZero("reset");
    rst = 1'b0;
    @(negedge clk);

    $display("[TB] table-driven vectors");
    for (int i = 0; i < 13; i++) begin
      runVector(vecs[i]);
    end

    // Flush in the second REQ cycle; memory acks two cycles later.
    $display("[TB] flush during request");
    applyStimulus(6'd0, 32'h0000_0100, 32'h0000_0004, 32'h0, 6'd3, 4'd7);
    @(negedge clk);
    clearIssue();
    checkOutput("fl_req1", {31'h0, mem_req}, 32'h1);
    @(negedge clk);
    checkOutput("fl_req2", {31'h0, mem_req}, 32'h1);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    for (int k = 0; k < 2; k++) begin
      checkOutput($sformatf("fl_drain_req%0d", k), {31'h0, mem_req}, 32'h1);
      checkOutput($sformatf("fl_drain_addr%0d", k), mem_addr, 32'h0000_0104);
      checkOutput($sformatf("fl_drain_busy%0d", k), {31'h0, DU_busy}, 32'h1);
      checkOutput($sformatf("fl_drain_commit%0d", k), {31'h0, DU_Commit}, 32'h0);
      if (k == 1) begin
        mem_ack   = 1'b1;
        mem_rdata = 32'h1111_2222;
      end
      @(negedge clk);
    end
    mem_ack   = 1'b0;
    mem_rdata = 32'h0;
    checkOutput("fl_after_busy", {31'h0, DU_busy}, 32'h0);
    checkOutput("fl_after_commit", {31'h0, DU_Commit}, 32'h0);
    checkOutput("fl_after_req", {31'h0, mem_req}, 32'h0);
    runVector(vecs[0]);

    // Issue attempts while busy must be ignored.
    $display("[TB] issue while busy");
    applyStimulus(6'd5, 32'h0000_0800, 32'h0, 32'h1122_3344, 6'd21, 4'd3);
    @(negedge clk);
    applyStimulus(6'd0, 32'h0000_0900, 32'h0, 32'h0, 6'd22, 4'd4);
    checkOutput("bb_addr1", mem_addr, 32'h0000_0800);
    checkOutput("bb_we1", {31'h0, mem_we}, 32'h1);
    @(negedge clk);
    clearIssue();
    checkOutput("bb_addr2", mem_addr, 32'h0000_0800);
    checkOutput("bb_req2", {31'h0, mem_req}, 32'h1);
    mem_ack = 1'b1;
    @(negedge clk);
    mem_ack = 1'b0;
    checkOutput("bb_commit", {31'h0, DU_Commit}, 32'h1);
    checkOutput("bb_phydst", {26'h0, DU_Phydst}, 32'd21);
    checkOutput("bb_window", {28'h0, WB_DU_Commit_Window}, 32'd3);
    checkOutput("bb_wdata", DU_wdata, 32'h0);
    applyStimulus(6'd0, 32'h0000_0900, 32'h0, 32'h0, 6'd22, 4'd4);
    @(negedge clk);
    clearIssue();
    checkOutput("bb_idle_req", {31'h0, mem_req}, 32'h0);
    checkOutput("bb_idle_busy", {31'h0, DU_busy}, 32'h0);
    @(negedge clk);
    checkOutput("bb_still_no_req", {31'h0, mem_req}, 32'h0);
    checkOutput("bb_no_commit", {31'h0, DU_Commit}, 32'h0);

    // Flush in the writeback cycle suppresses the commit pulse.
    $display("[TB] flush during writeback");
    applyStimulus(6'd0, 32'h0000_0020, 32'h0, 32'h0, 6'd5, 4'd2);
    @(negedge clk);
    clearIssue();
    mem_ack   = 1'b1;
    mem_rdata = 32'h0000_0055;
    @(negedge clk);
    mem_ack = 1'b0;
    flush   = 1'b1;
    #1;
    checkOutput("flwb_commit", {31'h0, DU_Commit}, 32'h0);
    checkOutput("flwb_fault", {31'h0, DU_fault}, 32'h0);
    @(negedge clk);
    flush = 1'b0;
    checkOutput("flwb_idle", {31'h0, DU_busy}, 32'h0);
    checkOutput("flwb_no_commit", {31'h0, DU_Commit}, 32'h0);

    // Flush alongside an issue in IDLE drops the issue, including a faulting one.
    $display("[TB] flush with issue in idle");
    applyStimulus(6'd0, 32'h0000_0100, 32'h0000_0001, 32'h0, 6'd6, 4'd1);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    clearIssue();
    checkOutput("flid_commit", {31'h0, DU_Commit}, 32'h0);
    checkOutput("flid_busy", {31'h0, DU_busy}, 32'h0);
    checkOutput("flid_req", {31'h0, mem_req}, 32'h0);

    // Reset during an outstanding request abandons it.
    $display("[TB] reset during request");
    applyStimulus(6'd0, 32'h0000_0100, 32'h0000_0008, 32'h0, 6'd20, 4'd9);
    @(negedge clk);
    clearIssue();
    checkOutput("rst_req_before", {31'h0, mem_req}, 32'h1);
    rst = 1'b1;
    @(negedge clk);
    checkAllZero("rst_req");
    rst = 1'b0;
    @(negedge clk);
    runVector(vecs[1]);

    $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
    $finish;
  end

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] timeout");
  end

endmodule
